// File: rtl/ysyx_ifu.sv
// rtl/ysyx_ifu.sv - instruction fetch unit: one outstanding imem request, single-entry hold buffer
module ysyx_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] redirect_tgt;
    logic        req_fire;

    // A halt in REQ suppresses the request so nothing is left in flight when we stop.
    assign imem_req_valid = (state_q == S_REQ) && !halt;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign inst_valid     = (state_q == S_HOLD);
    assign halted         = (state_q == S_HALTED);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_cnt      = cnt_q;
    assign redirect_tgt   = redirect_pc & ~32'h3;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = req_fire ? S_DRAIN : S_REQ;
                end else if (halt) begin
                    state_d = S_HALTED;
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (imem_rsp_valid) begin
                    inst_d    = imem_rsp_data;
                    inst_pc_d = pc_q;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                    if (inst_ready) cnt_d = cnt_q + 32'd1;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) pc_d = redirect_tgt;
                if (imem_rsp_valid) state_d = S_REQ;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0000_0013;
            inst_pc_q <= 32'h0;
            cnt_q     <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_ifu.sv
// tb/tb_ysyx_ifu.sv - randomized and directed checks of ysyx_ifu against a transaction-level model
module tb_ysyx_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic [31:0] fetch_cnt;

    ysyx_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .halted(halted), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // staged stimulus, applied at the next falling edge
    bit          s_ready, s_ir, s_redir, s_halt;
    logic [31:0] s_rpc;

    // model: pc, a hold slot, an in-flight flag and whether that in-flight word is stale
    logic [31:0] m_pc, m_inst, m_inst_pc, m_cnt;
    bit          m_held, m_inflight, m_discard, m_halted;

    // memory: single outstanding request with a latency countdown
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_data;
    int          lat_cfg;
    bit          ovr_en;
    logic [31:0] ovr;

    bit          exp_rv, smp_req_valid;
    logic [31:0] smp_req_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic model_reset();
        m_pc = 32'h8000_0000; m_inst = 32'h13; m_inst_pc = 32'h0; m_cnt = 32'h0;
        m_held = 0; m_inflight = 0; m_discard = 0; m_halted = 0;
        mem_busy = 0; mem_cnt = 0; mem_data = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        inst_ready = 0; redirect_valid = 0; redirect_pc = 0; halt = 0;
        s_ready = 0; s_ir = 0; s_redir = 0; s_rpc = 0; s_halt = 0;
        #1;
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fetch_cnt", fetch_cnt, 32'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic sample();
        @(negedge clk);
        imem_req_ready = s_ready; inst_ready = s_ir; redirect_valid = s_redir;
        redirect_pc = s_rpc; halt = s_halt;
        imem_rsp_valid = mem_busy && (mem_cnt == 0);
        imem_rsp_data  = imem_rsp_valid ? mem_data : $urandom;
        #1;
        exp_rv = !m_halted && !m_held && !m_inflight && !halt;
        chk("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", inst_valid, m_held);
        if (m_held) begin
            chk("inst", inst, m_inst);
            chk("inst_pc", inst_pc, m_inst_pc);
        end
        chk("halted", halted, m_halted);
        chk("fetch_cnt", fetch_cnt, m_cnt);
        smp_req_valid = imem_req_valid;
        smp_req_addr  = imem_req_addr;
    endtask

    task automatic advance();
        bit fire;
        bit accept;
        fire   = smp_req_valid && imem_req_ready;
        accept = exp_rv && imem_req_ready;
        if (!m_halted) begin
            if (redirect_valid) begin
                if (m_held) begin
                    if (inst_ready) m_cnt = m_cnt + 1;
                    m_held = 0;
                end else if (m_inflight) begin
                    if (imem_rsp_valid) begin m_inflight = 0; m_discard = 0; end
                    else m_discard = 1;
                end else if (accept) begin
                    m_inflight = 1; m_discard = 1;
                end
                m_pc = redirect_pc & ~32'h3;
            end else if (m_held) begin
                if (inst_ready) begin m_pc = m_pc + 4; m_cnt = m_cnt + 1; m_held = 0; end
            end else if (m_inflight) begin
                if (imem_rsp_valid) begin
                    if (!m_discard) begin
                        m_held = 1; m_inst = imem_rsp_data; m_inst_pc = m_pc;
                    end
                    m_inflight = 0; m_discard = 0;
                end
            end else if (halt) begin
                m_halted = 1;
            end else if (accept) begin
                m_inflight = 1; m_discard = 0;
            end
        end
        if (imem_rsp_valid) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (fire) begin
            chk("one_outstanding", mem_busy, 1'b0);
            mem_busy = 1;
            mem_cnt  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
            mem_data = ovr_en ? ovr : data_fn(smp_req_addr);
        end
        @(posedge clk);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        lat_cfg = 0; ovr_en = 0; ovr = 0;
        model_reset();
        do_reset();

        // first delivery
        s_ready = 1; s_ir = 1; ovr_en = 1; ovr = 32'h0010_0093;
        sample(); chk("t34_req_valid", imem_req_valid, 1'b1); chk("t34_addr", imem_req_addr, 32'h8000_0000); advance();
        sample(); advance();
        sample(); chk("t34_inst_valid", inst_valid, 1'b1); chk("t34_inst", inst, 32'h0010_0093);
        chk("t34_inst_pc", inst_pc, 32'h8000_0000); advance();
        sample(); chk("t34_next_addr", imem_req_addr, 32'h8000_0004); chk("t34_cnt", fetch_cnt, 32'd1); advance();

        // decoder backpressure
        do_reset();
        s_ready = 1; s_ir = 0; ovr = 32'h0020_0113;
        sample(); advance();
        sample(); advance();
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("t35_hold_valid", inst_valid, 1'b1); chk("t35_no_req", imem_req_valid, 1'b0);
            chk("t35_inst", inst, 32'h0020_0113); chk("t35_inst_pc", inst_pc, 32'h8000_0000);
            advance();
        end
        s_ir = 1; sample(); advance();
        s_ir = 0; sample(); chk("t35_addr", imem_req_addr, 32'h8000_0004); chk("t35_cnt", fetch_cnt, 32'd1); advance();

        // redirect in WAIT with a late stale response
        do_reset();
        s_ready = 1; s_ir = 1; lat_cfg = 3; ovr = 32'hDEAD_BEEF;
        sample(); advance();
        ovr_en = 0; lat_cfg = 0;
        s_redir = 1; s_rpc = 32'h8000_0102;
        sample(); advance();
        s_redir = 0; seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            sample();
            chk("t36_no_stale", inst_valid && (inst == 32'hDEAD_BEEF), 1'b0);
            if (imem_req_valid) begin seen = 1; chk("t36_addr", imem_req_addr, 32'h8000_0100); end
            advance();
        end
        chk("t36_reached_req", seen, 1'b1);
        for (int i = 0; i < 4; i++) begin
            sample(); chk("t36_no_stale", inst_valid && (inst == 32'hDEAD_BEEF), 1'b0); advance();
        end

        // redirect and consume together in HOLD
        do_reset();
        s_ready = 1; s_ir = 0;
        sample(); advance();
        s_ready = 0; sample(); advance();
        s_redir = 1; s_rpc = 32'h8000_0040; s_ir = 1;
        sample(); chk("t37_hold", inst_valid, 1'b1); advance();
        s_redir = 0; s_ir = 0;
        sample(); chk("t37_addr", imem_req_addr, 32'h8000_0040); chk("t37_cnt", fetch_cnt, 32'd1); advance();

        // halt
        do_reset();
        s_halt = 1;
        sample(); chk("t38_no_req", imem_req_valid, 1'b0); advance();
        s_halt = 0; s_redir = 1; s_rpc = 32'h1234_5678; s_ready = 1;
        for (int i = 0; i < 4; i++) begin
            sample(); chk("t38_halted", halted, 1'b1); chk("t38_no_req", imem_req_valid, 1'b0); advance();
        end
        do_reset();
        sample(); chk("t38_restart_valid", imem_req_valid, 1'b1); chk("t38_restart_addr", imem_req_addr, 32'h8000_0000);
        chk("t38_not_halted", halted, 1'b0); advance();

        // pc wrap
        do_reset();
        s_redir = 1; s_rpc = 32'hFFFF_FFFF;
        sample(); advance();
        s_redir = 0; s_ready = 1; s_ir = 1;
        sample(); chk("t39_addr", imem_req_addr, 32'hFFFF_FFFC); advance();
        sample(); advance();
        sample(); chk("t39_inst_pc", inst_pc, 32'hFFFF_FFFC); advance();
        sample(); chk("t39_wrap", imem_req_addr, 32'h0000_0000); advance();

        // randomized traffic
        do_reset();
        lat_cfg = -1; ovr_en = 0;
        for (int i = 0; i < 4000; i++) begin
            s_ready = 1'($urandom_range(0, 1));
            s_ir    = ($urandom % 10) < 6;
            s_redir = ($urandom % 10) == 0;
            s_rpc   = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            s_halt  = ($urandom % 150) == 0;
            sample();
            advance();
            if ((m_halted && ($urandom % 8) == 0) || ($urandom % 700) == 0) begin
                do_reset();
                lat_cfg = -1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
